// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter: pipeline writebacks win, long-latency results queue

module wb_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [AW-1:0]            pipe_waddr,
    input  logic [DW-1:0]            pipe_wdata,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [AW-1:0]            lu_waddr,
    input  logic [DW-1:0]            lu_wdata,
    input  logic [AW-1:0]            qaddr1,
    input  logic [AW-1:0]            qaddr2,
    output logic                     busy1,
    output logic                     busy2,
    output logic                     wb_we,
    output logic [AW-1:0]            wb_waddr,
    output logic [DW-1:0]            wb_wdata,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]  entry_valid;
    logic [AW-1:0]     entry_addr [DEPTH];
    logic [DW-1:0]     entry_data [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    logic pipe_live;
    logic lu_hs;
    logic lu_nonzero;
    logic fifo_empty;
    logic do_pop;
    logic do_bypass;
    logic do_push;
    logic push_valid;

    assign pipe_live  = pipe_we && (pipe_waddr != '0);
    assign lu_ready   = (fifo_count < CW'(DEPTH));
    assign lu_hs      = lu_valid && lu_ready;
    assign lu_nonzero = (lu_waddr != '0);
    assign fifo_empty = (fifo_count == '0);
    assign do_pop     = !pipe_live && !fifo_empty;
    assign do_bypass  = !pipe_live && fifo_empty && lu_hs && lu_nonzero;
    assign do_push    = lu_hs && lu_nonzero && !do_bypass;
    // A concurrently offered lu result is older than the live pipe write to the same register.
    assign push_valid = !(pipe_live && (lu_waddr == pipe_waddr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we    <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
        end else if (pipe_live) begin
            wb_we    <= 1'b1;
            wb_waddr <= pipe_waddr;
            wb_wdata <= pipe_wdata;
        end else if (do_pop) begin
            wb_we    <= entry_valid[rd_ptr];
            wb_waddr <= entry_addr[rd_ptr];
            wb_wdata <= entry_data[rd_ptr];
        end else if (do_bypass) begin
            wb_we    <= 1'b1;
            wb_waddr <= lu_waddr;
            wb_wdata <= lu_wdata;
        end else begin
            wb_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_valid <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_addr[i] <= '0;
                entry_data[i] <= '0;
            end
        end else begin
            // Squash older queued results superseded by a live pipe write.
            if (pipe_live) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entry_addr[i] == pipe_waddr) begin
                        entry_valid[i] <= 1'b0;
                    end
                end
            end
            // Clearing valid on pop keeps busy limited to occupied slots.
            if (do_pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + PW'(1);
            end
            // A push never targets the slot being popped: a push needs count < DEPTH.
            if (do_push) begin
                entry_valid[wr_ptr] <= push_valid;
                entry_addr[wr_ptr]  <= lu_waddr;
                entry_data[wr_ptr]  <= lu_wdata;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == qaddr1)) busy1 = 1'b1;
            if (entry_valid[i] && (entry_addr[i] == qaddr2)) busy2 = 1'b1;
        end
        if (qaddr1 == '0) busy1 = 1'b0;
        if (qaddr2 == '0) busy2 = 1'b0;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter

module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic [4:0]  qaddr1;
    logic [4:0]  qaddr2;
    logic        busy1;
    logic        busy2;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [2:0]  fifo_count;

    int n_assert = 0;
    int n_fail   = 0;

    wb_port_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .qaddr1     (qaddr1),
        .qaddr2     (qaddr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
        pipe_we = we; pipe_waddr = a; pipe_wdata = d;
    endtask

    task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lu_valid = v; lu_waddr = a; lu_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        pipe(0, 0, 0);
        lu(0, 0, 0);
        qaddr1 = 0;
        qaddr2 = 0;
        tick();
        tick();
        chk("rst_we", wb_we, 0);
        chk("rst_addr", wb_waddr, 0);
        chk("rst_data", wb_wdata, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", lu_ready, 1);
        chk("rst_busy1", busy1, 0);
        rst = 1'b0;
        tick();

        // T2 pipe only
        pipe(1, 5, 32'h1234);
        tick();
        chk("t2_we", wb_we, 1);
        chk("t2_addr", wb_waddr, 5);
        chk("t2_data", wb_wdata, 32'h1234);
        pipe(1, 0, 32'h55);
        tick();
        chk("t2_r0_we", wb_we, 0);
        chk("t2_r0_addr_hold", wb_waddr, 5);
        chk("t2_r0_data_hold", wb_wdata, 32'h1234);
        pipe(0, 0, 0);

        // T3 bypass and queue
        lu(1, 8, 32'hAA);
        tick();
        chk("t3_byp_we", wb_we, 1);
        chk("t3_byp_addr", wb_waddr, 8);
        chk("t3_byp_data", wb_wdata, 32'hAA);
        chk("t3_byp_count", fifo_count, 0);
        pipe(1, 3, 32'h33);
        qaddr1 = 8;
        tick();
        chk("t3_pipe_addr", wb_waddr, 3);
        chk("t3_pipe_data", wb_wdata, 32'h33);
        chk("t3_q_count", fifo_count, 1);
        chk("t3_busy1", busy1, 1);
        pipe(0, 0, 0);
        lu(0, 0, 0);
        tick();
        chk("t3_drain_we", wb_we, 1);
        chk("t3_drain_addr", wb_waddr, 8);
        chk("t3_drain_data", wb_wdata, 32'hAA);
        chk("t3_drain_count", fifo_count, 0);
        chk("t3_busy1_clr", busy1, 0);

        // lu handshake to r0 is accepted and dropped
        lu(1, 0, 32'h77);
        tick();
        chk("r0_lu_we", wb_we, 0);
        chk("r0_lu_count", fifo_count, 0);
        lu(0, 0, 0);

        // T4 full
        for (int k = 0; k < 4; k++) begin
            pipe(1, 1, k);
            lu(1, 5'(9 + k), 32'h90 + k);
            tick();
            chk("t4_fill_count", fifo_count, k + 1);
        end
        chk("t4_full_ready", lu_ready, 0);
        for (int k = 0; k < 2; k++) begin
            pipe(1, 1, 4 + k);
            lu(1, 13, 32'h94);
            tick();
            chk("t4_full_count", fifo_count, 4);
            chk("t4_full_pipe_addr", wb_waddr, 1);
        end
        pipe(0, 0, 0);
        tick();
        chk("t4_pop0_addr", wb_waddr, 9);
        chk("t4_pop0_count", fifo_count, 3);
        chk("t4_pop0_ready", lu_ready, 1);
        tick();
        chk("t4_pop1_addr", wb_waddr, 10);
        chk("t4_pop1_count", fifo_count, 3);
        lu(0, 0, 0);
        for (int k = 2; k < 5; k++) begin
            tick();
            chk("t4_drain_we", wb_we, 1);
            chk("t4_drain_addr", wb_waddr, 9 + k);
            chk("t4_drain_data", wb_wdata, 32'h90 + k);
            chk("t4_drain_count", fifo_count, 4 - k);
        end

        // T5 WAW squash of a queued entry
        qaddr2 = 7;
        pipe(1, 2, 32'h22);
        lu(1, 7, 32'h1);
        tick();
        chk("t5_q_count", fifo_count, 1);
        chk("t5_busy2", busy2, 1);
        lu(0, 0, 0);
        pipe(1, 7, 32'h2);
        tick();
        chk("t5_pipe_addr", wb_waddr, 7);
        chk("t5_pipe_data", wb_wdata, 32'h2);
        chk("t5_busy2_clr", busy2, 0);
        chk("t5_sq_count", fifo_count, 1);
        pipe(0, 0, 0);
        tick();
        chk("t5_drain_we", wb_we, 0);
        chk("t5_drain_count", fifo_count, 0);

        // same-cycle squash of an entry being enqueued
        qaddr1 = 6;
        pipe(1, 6, 32'h66);
        lu(1, 6, 32'h60);
        tick();
        chk("sc_count", fifo_count, 1);
        chk("sc_busy1", busy1, 0);
        pipe(0, 0, 0);
        lu(0, 0, 0);
        tick();
        chk("sc_drain_we", wb_we, 0);
        chk("sc_drain_count", fifo_count, 0);

        // T6 wrap with simultaneous push and pop
        pipe(1, 1, 32'h11);
        lu(1, 16, 32'd100);
        tick();
        chk("t6_prime_count", fifo_count, 1);
        pipe(0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            lu(1, 5'(16 + k), 32'd100 + k);
            tick();
            chk("t6_addr", wb_waddr, 16 + k - 1);
            chk("t6_data", wb_wdata, 100 + k - 1);
            chk("t6_count", fifo_count, 1);
        end
        lu(0, 0, 0);
        tick();
        chk("t6_last_data", wb_wdata, 112);
        chk("t6_last_count", fifo_count, 0);

        // T1 asynchronous reset mid-cycle with a queued entry
        pipe(1, 3, 32'h3);
        lu(1, 4, 32'h4);
        tick();
        chk("t1_pre_count", fifo_count, 1);
        chk("t1_pre_we", wb_we, 1);
        pipe(0, 0, 0);
        lu(0, 0, 0);
        qaddr1 = 4;
        #2;
        rst = 1'b1;
        #1;
        chk("t1_we", wb_we, 0);
        chk("t1_count", fifo_count, 0);
        chk("t1_ready", lu_ready, 1);
        chk("t1_busy1", busy1, 0);
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
